// File: rtl/mcdt_fmt_pkg.sv
// rtl/mcdt_fmt_pkg.sv - shared types, defaults and round-robin helpers for the mcdt formatter
package mcdt_fmt_pkg;
  localparam int NUM_CH         = 3;
  localparam int DEF_PKT_LEN    = 4;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND
  } fmt_state_e;

  function automatic logic [1:0] rr_inc(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // First eligible channel scanning rr, rr+1, rr+2 (mod 3); only called with some bit of elig set.
  function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] rr);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_inc(rr);
    c2 = rr_inc(c1);
    if (elig[rr]) return rr;
    if (elig[c1]) return c1;
    return c2;
  endfunction
endpackage

// File: rtl/mcdt_fmt_fifo.sv
// rtl/mcdt_fmt_fifo.sv - per-channel show-ahead word buffer with registered count
module mcdt_fmt_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [31:0]   wdata,
  input  logic          pop,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full buffer is dropped even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mcdt_formatter.sv
// rtl/mcdt_formatter.sv - buffers mcdt words per channel and emits fixed-length packets round-robin
module mcdt_formatter
  import mcdt_fmt_pkg::*;
#(
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mcdt_data_i,
  input  logic        mcdt_val_i,
  input  logic [1:0]  mcdt_id_i,
  output logic        fmt_req_o,
  input  logic        fmt_grant_i,
  output logic [1:0]  fmt_chid_o,
  output logic [7:0]  fmt_length_o,
  output logic        fmt_valid_o,
  output logic [31:0] fmt_data_o,
  output logic        fmt_start_o,
  output logic        fmt_end_o,
  output logic [17:0] ch_margin_o,
  output logic [2:0]  ovf_o,
  output logic        bad_id_o
);
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]    LEN8      = 8'(PKT_LEN);
  localparam logic [7:0]    LAST_BEAT = 8'(PKT_LEN - 1);

  fmt_state_e        state;
  fmt_state_e        state_n;
  logic [1:0]        chid;
  logic [1:0]        chid_n;
  logic [1:0]        rr;
  logic [1:0]        rr_n;
  logic [7:0]        beat;
  logic [7:0]        beat_n;
  logic [2:0]        ovf;
  logic              bad_id;

  logic [CW-1:0]     cnt   [NUM_CH];
  logic [31:0]       rdata [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] elig;
  logic [31:0]       sel_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = mcdt_val_i && (mcdt_id_i == 2'(k));
    assign elig[k] = (cnt[k] >= CW'(PKT_LEN));
    assign ch_margin_o[6*k +: 6] = 6'(FIFO_DEPTH) - 6'(cnt[k]);

    mcdt_fmt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[k]),
      .wdata (mcdt_data_i),
      .pop   (pop[k]),
      .rdata (rdata[k]),
      .count (cnt[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= ST_IDLE;
      chid   <= '0;
      rr     <= '0;
      beat   <= '0;
      ovf    <= '0;
      bad_id <= 1'b0;
    end else begin
      state  <= state_n;
      chid   <= chid_n;
      rr     <= rr_n;
      beat   <= beat_n;
      ovf    <= ovf | (push & full);
      bad_id <= bad_id | (mcdt_val_i && (mcdt_id_i == 2'd3));
    end
  end

  always_comb begin
    state_n      = state;
    chid_n       = chid;
    rr_n         = rr;
    beat_n       = beat;
    fmt_req_o    = 1'b0;
    fmt_valid_o  = 1'b0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    fmt_length_o = '0;
    pop          = '0;
    case (state)
      ST_IDLE: begin
        if (|elig) begin
          state_n = ST_REQ;
          chid_n  = rr_pick(elig, rr);
        end
      end
      ST_REQ: begin
        fmt_req_o    = 1'b1;
        fmt_length_o = LEN8;
        if (fmt_grant_i) begin
          state_n = ST_SEND;
          rr_n    = rr_inc(chid);
          beat_n  = '0;
        end
      end
      ST_SEND: begin
        // The chosen buffer held at least PKT_LEN words at selection, so a beat never starves.
        fmt_valid_o  = 1'b1;
        fmt_length_o = LEN8;
        pop          = (3'b001 << chid) & ~empty;
        fmt_start_o  = (beat == 8'd0);
        fmt_end_o    = (beat == LAST_BEAT);
        if (beat == LAST_BEAT) state_n = ST_IDLE;
        else                   beat_n  = beat + 8'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_data = rdata[0];
    case (chid)
      2'd1:    sel_data = rdata[1];
      2'd2:    sel_data = rdata[2];
      default: sel_data = rdata[0];
    endcase
  end

  assign fmt_data_o = fmt_valid_o ? sel_data : '0;
  assign fmt_chid_o = chid;
  assign ovf_o      = ovf;
  assign bad_id_o   = bad_id;
endmodule

// File: tb/tb_mcdt_formatter.sv
// tb/tb_mcdt_formatter.sv - directed self-checking bench for mcdt_formatter
module tb_mcdt_formatter;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] mcdt_data_i = '0;
  logic        mcdt_val_i = 1'b0;
  logic [1:0]  mcdt_id_i = '0;
  logic        fmt_req_o;
  logic        fmt_grant_i = 1'b0;
  logic [1:0]  fmt_chid_o;
  logic [7:0]  fmt_length_o;
  logic        fmt_valid_o;
  logic [31:0] fmt_data_o;
  logic        fmt_start_o;
  logic        fmt_end_o;
  logic [17:0] ch_margin_o;
  logic [2:0]  ovf_o;
  logic        bad_id_o;

  int checks = 0;
  int errors = 0;

  logic          cap_ok;
  logic [1:0]    cap_ch;
  logic [7:0]    cap_len;
  logic [31:0]   cap_data [PL];
  logic [5:0]    cap_mg   [PL];
  logic [PL-1:0] cap_val;
  logic [PL-1:0] cap_st;
  logic [PL-1:0] cap_en;

  mcdt_formatter dut (
    .clk          (clk),
    .rstn         (rstn),
    .mcdt_data_i  (mcdt_data_i),
    .mcdt_val_i   (mcdt_val_i),
    .mcdt_id_i    (mcdt_id_i),
    .fmt_req_o    (fmt_req_o),
    .fmt_grant_i  (fmt_grant_i),
    .fmt_chid_o   (fmt_chid_o),
    .fmt_length_o (fmt_length_o),
    .fmt_valid_o  (fmt_valid_o),
    .fmt_data_o   (fmt_data_o),
    .fmt_start_o  (fmt_start_o),
    .fmt_end_o    (fmt_end_o),
    .ch_margin_o  (ch_margin_o),
    .ovf_o        (ovf_o),
    .bad_id_o     (bad_id_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mcdt_val_i  = 1'b0;
    fmt_grant_i = 1'b0;
    rstn = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic push_word(input logic [1:0] id, input logic [31:0] d);
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = id;
    mcdt_data_i = d;
    tick();
    mcdt_val_i = 1'b0;
  endtask

  // Waits for a request, grants it and records every beat; optionally pushes on selected beats.
  task automatic get_packet(input logic [PL-1:0] mask, input logic [1:0] pid,
                            input logic [31:0] pbase);
    int n;
    n = 0;
    cap_ok = 1'b0;
    while (!fmt_req_o && n < 60) begin
      tick();
      n++;
    end
    if (fmt_req_o) begin
      cap_ok  = 1'b1;
      cap_ch  = fmt_chid_o;
      cap_len = fmt_length_o;
      fmt_grant_i = 1'b1;
      tick();
      fmt_grant_i = 1'b0;
      for (int b = 0; b < PL; b++) begin
        cap_data[b] = fmt_data_o;
        cap_val[b]  = fmt_valid_o;
        cap_st[b]   = fmt_start_o;
        cap_en[b]   = fmt_end_o;
        cap_mg[b]   = ch_margin_o[6*cap_ch +: 6];
        if (mask[b]) begin
          mcdt_val_i  = 1'b1;
          mcdt_id_i   = pid;
          mcdt_data_i = pbase + 32'(b);
        end
        tick();
        mcdt_val_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    tick();
    checks++; if (fmt_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", fmt_req_o); end
    checks++; if (fmt_valid_o !== 1'b0 || fmt_start_o !== 1'b0 || fmt_end_o !== 1'b0) begin
      errors++; $display("FAIL reset_beat got=%b%b%b exp=000", fmt_valid_o, fmt_start_o, fmt_end_o); end
    checks++; if (fmt_data_o !== 32'd0 || fmt_chid_o !== 2'd0 || fmt_length_o !== 8'd0) begin
      errors++; $display("FAIL reset_data got=%h/%0d/%0d exp=0/0/0", fmt_data_o, fmt_chid_o, fmt_length_o); end
    checks++; if (ch_margin_o !== {6'd16, 6'd16, 6'd16}) begin
      errors++; $display("FAIL reset_margin got=%h exp=%h", ch_margin_o, {6'd16, 6'd16, 6'd16}); end
    checks++; if (ovf_o !== 3'b000 || bad_id_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b/%b exp=000/0", ovf_o, bad_id_o); end
    rstn = 1'b0;
  endtask

  task automatic test_single;
    int n;
    for (int i = 0; i < 4; i++) push_word(2'd0, 32'h00C0_0000 + 32'(i));
    checks++; if (ch_margin_o[5:0] !== 6'd12) begin
      errors++; $display("FAIL single_margin got=%0d exp=12", ch_margin_o[5:0]); end
    n = 0;
    while (!fmt_req_o && n < 20) begin tick(); n++; end
    checks++; if (fmt_req_o !== 1'b1) begin errors++; $display("FAIL single_req_timeout got=%b exp=1", fmt_req_o); end
    for (int h = 0; h < 3; h++) begin
      tick();
      checks++; if (fmt_req_o !== 1'b1 || fmt_chid_o !== 2'd0 || fmt_length_o !== 8'd4 || fmt_valid_o !== 1'b0) begin
        errors++; $display("FAIL single_hold got=%b/%0d/%0d/%b exp=1/0/4/0",
                           fmt_req_o, fmt_chid_o, fmt_length_o, fmt_valid_o); end
    end
    get_packet('0, 2'd0, 32'd0);
    checks++; if (cap_ok !== 1'b1 || cap_ch !== 2'd0 || cap_len !== 8'd4) begin
      errors++; $display("FAIL single_hdr got=%b/%0d/%0d exp=1/0/4", cap_ok, cap_ch, cap_len); end
    checks++; if (cap_val !== 4'b1111 || cap_st !== 4'b0001 || cap_en !== 4'b1000) begin
      errors++; $display("FAIL single_flags got=%b/%b/%b exp=1111/0001/1000", cap_val, cap_st, cap_en); end
    for (int b = 0; b < PL; b++) begin
      checks++; if (cap_data[b] !== 32'h00C0_0000 + 32'(b)) begin
        errors++; $display("FAIL single_data[%0d] got=%h exp=%h", b, cap_data[b], 32'h00C0_0000 + 32'(b)); end
    end
    checks++; if (fmt_req_o !== 1'b0 || fmt_valid_o !== 1'b0 || fmt_data_o !== 32'd0 || ch_margin_o[5:0] !== 6'd16) begin
      errors++; $display("FAIL single_after got=%b/%b/%h/%0d exp=0/0/0/16",
                         fmt_req_o, fmt_valid_o, fmt_data_o, ch_margin_o[5:0]); end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp;
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) push_word(2'(c), 32'hA000_0000 + 32'(c * 32'h1_0000) + 32'(i));
    for (int p = 0; p < 6; p++) begin
      get_packet('0, 2'd0, 32'd0);
      checks++; if (cap_ok !== 1'b1 || cap_ch !== 2'(p % 3)) begin
        errors++; $display("FAIL rr_order[%0d] got=%b/%0d exp=1/%0d", p, cap_ok, cap_ch, p % 3); end
      for (int b = 0; b < PL; b++) begin
        exp = 32'hA000_0000 + 32'((p % 3) * 32'h1_0000) + 32'((p / 3) * 4 + b);
        checks++; if (cap_data[b] !== exp) begin
          errors++; $display("FAIL rr_data[%0d][%0d] got=%h exp=%h", p, b, cap_data[b], exp); end
      end
      checks++; if (fmt_req_o !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d] got=%b exp=0", p, fmt_req_o); end
    end
  endtask

  task automatic test_overflow;
    logic seen;
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) push_word(2'd1, 32'hB100_0000 + 32'(i));
    checks++; if (ch_margin_o[11:6] !== 6'd0 || ovf_o !== 3'b010) begin
      errors++; $display("FAIL ovf_full got=%0d/%b exp=0/010", ch_margin_o[11:6], ovf_o); end
    for (int p = 0; p < 4; p++) begin
      get_packet((p == 0) ? 4'b0001 : 4'b0000, 2'd1, 32'hDEAD_0000);
      checks++; if (cap_ok !== 1'b1 || cap_ch !== 2'd1) begin
        errors++; $display("FAIL ovf_hdr[%0d] got=%b/%0d exp=1/1", p, cap_ok, cap_ch); end
      if (p == 0) begin
        checks++; if (cap_mg[1] !== 6'd1) begin
          errors++; $display("FAIL ovf_full_pushpop got=%0d exp=1", cap_mg[1]); end
      end
      for (int b = 0; b < PL; b++) begin
        exp = 32'hB100_0000 + 32'(p * 4 + b);
        checks++; if (cap_data[b] !== exp) begin
          errors++; $display("FAIL ovf_data[%0d][%0d] got=%h exp=%h", p, b, cap_data[b], exp); end
      end
    end
    checks++; if (ch_margin_o[11:6] !== 6'd16 || ovf_o !== 3'b010) begin
      errors++; $display("FAIL ovf_drained got=%0d/%b exp=16/010", ch_margin_o[11:6], ovf_o); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= fmt_req_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ovf_lost_words got=req exp=none"); end
  endtask

  task automatic test_bad_id;
    push_word(2'd3, 32'h3333_3333);
    checks++; if (bad_id_o !== 1'b1) begin errors++; $display("FAIL bad_id got=%b exp=1", bad_id_o); end
    checks++; if (ch_margin_o !== {6'd16, 6'd16, 6'd16} || ovf_o !== 3'b010) begin
      errors++; $display("FAIL bad_id_side got=%h/%b exp=%h/010", ch_margin_o, ovf_o, {6'd16, 6'd16, 6'd16}); end
  endtask

  task automatic test_reset_mid_send;
    int n;
    logic seen_end;
    logic seen_val;
    for (int i = 0; i < 4; i++) push_word(2'd0, 32'hE000_0000 + 32'(i));
    n = 0;
    while (!fmt_req_o && n < 20) begin tick(); n++; end
    fmt_grant_i = 1'b1;
    tick();
    fmt_grant_i = 1'b0;
    tick();
    tick();
    checks++; if (fmt_valid_o !== 1'b1 || fmt_data_o !== 32'hE000_0002) begin
      errors++; $display("FAIL mid_beat2 got=%b/%h exp=1/e0000002", fmt_valid_o, fmt_data_o); end
    #2 rstn = 1'b1;
    #1;
    checks++; if (fmt_valid_o !== 1'b0 || fmt_end_o !== 1'b0 || fmt_req_o !== 1'b0 || fmt_data_o !== 32'd0) begin
      errors++; $display("FAIL mid_abort got=%b/%b/%b/%h exp=0/0/0/0", fmt_valid_o, fmt_end_o, fmt_req_o, fmt_data_o); end
    checks++; if (ch_margin_o !== {6'd16, 6'd16, 6'd16} || ovf_o !== 3'b000 || bad_id_o !== 1'b0 ||
                  fmt_chid_o !== 2'd0 || fmt_length_o !== 8'd0) begin
      errors++; $display("FAIL mid_state got=%h/%b/%b/%0d/%0d exp=%h/000/0/0/0",
                         ch_margin_o, ovf_o, bad_id_o, fmt_chid_o, fmt_length_o, {6'd16, 6'd16, 6'd16}); end
    seen_end = 1'b0;
    seen_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) rstn = 1'b0;
      seen_end |= fmt_end_o;
      seen_val |= fmt_valid_o | fmt_req_o;
    end
    checks++; if (seen_end !== 1'b0 || seen_val !== 1'b0) begin
      errors++; $display("FAIL mid_no_tail got=%b/%b exp=0/0", seen_end, seen_val); end
  endtask

  task automatic test_push_during_send;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(2'd2, 32'hD200_0000 + 32'(i));
    get_packet(4'b1111, 2'd2, 32'hD200_0004);
    checks++; if (cap_ok !== 1'b1 || cap_ch !== 2'd2 || cap_st !== 4'b0001 || cap_en !== 4'b1000) begin
      errors++; $display("FAIL ps_hdr got=%b/%0d/%b/%b exp=1/2/0001/1000", cap_ok, cap_ch, cap_st, cap_en); end
    for (int b = 0; b < PL; b++) begin
      checks++; if (cap_data[b] !== 32'hD200_0000 + 32'(b) || cap_mg[b] !== 6'd12) begin
        errors++; $display("FAIL ps_beat[%0d] got=%h/%0d exp=%h/12", b, cap_data[b], cap_mg[b], 32'hD200_0000 + 32'(b)); end
    end
    checks++; if (ch_margin_o[17:12] !== 6'd12) begin
      errors++; $display("FAIL ps_count got=%0d exp=12", ch_margin_o[17:12]); end
    get_packet('0, 2'd0, 32'd0);
    for (int b = 0; b < PL; b++) begin
      checks++; if (cap_data[b] !== 32'hD200_0004 + 32'(b)) begin
        errors++; $display("FAIL ps_second[%0d] got=%h exp=%h", b, cap_data[b], 32'hD200_0004 + 32'(b)); end
    end
    checks++; if (ch_margin_o[17:12] !== 6'd16 || ovf_o !== 3'b000) begin
      errors++; $display("FAIL ps_drained got=%0d/%b exp=16/000", ch_margin_o[17:12], ovf_o); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_bad_id();
    test_reset_mid_send();
    test_push_during_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcdt_formatter.md
MCDT_FORMATTER -- requirements
Module: mcdt_formatter

Interface
REQ-001 SHALL have parameter PKT_LEN, default 4: data words per output packet (2..FIFO_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entries per channel buffer (power of two).
REQ-003 SHALL use reset rstn, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous reset, active-high (reset while rstn==1).
REQ-006 mcdt_data_i  input  32  arbitrated word from the mcdt stage.
REQ-007 mcdt_val_i  input  1  mcdt_data_i/mcdt_id_i valid this cycle; no backpressure.
REQ-008 mcdt_id_i  input  2  source channel 0..2; 3 is illegal.
REQ-009 fmt_req_o  output  1  packet ready, requesting the downstream slot.
REQ-010 fmt_grant_i  input  1  downstream accepts the request.
REQ-011 fmt_chid_o  output  2  channel of the pending or current packet.
REQ-012 fmt_length_o  output  8  equals PKT_LEN during REQ and SEND, 0 otherwise.
REQ-013 fmt_valid_o  output  1  fmt_data_o valid this cycle.
REQ-014 fmt_data_o  output  32  packet payload word.
REQ-015 fmt_start_o / fmt_end_o  output  1 each  first / last word of the packet.
REQ-016 ch_margin_o  output  3x6  per-channel free entries (FIFO_DEPTH - count).
REQ-017 ovf_o  output  3  per-channel sticky overflow flag.
REQ-018 bad_id_o  output  1  sticky flag: a valid word with id 3 was received.

Function
REQ-019 On each edge with mcdt_val_i=1 and id k (0..2), SHALL push mcdt_data_i into FIFO k if it is not full; otherwise SHALL drop the word and set ovf_o[k].
REQ-020 Valid words with id 3 SHALL be dropped and SHALL set bad_id_o.
REQ-021 A simultaneous push and pop on the same FIFO SHALL both occur, leaving count unchanged; a push to a full FIFO in the same cycle as a pop SHALL still be dropped.
REQ-022 FSM states SHALL be IDLE, REQ and SEND.
REQ-023 IDLE->REQ on an edge where any registered count >= PKT_LEN. The channel SHALL be chosen round-robin from pointer rr: first eligible of rr, rr+1, rr+2 (mod 3). fmt_chid_o SHALL latch the choice.
REQ-024 In REQ: fmt_req_o=1; fmt_chid_o and fmt_length_o SHALL be held stable; the FSM SHALL wait indefinitely for fmt_grant_i.
REQ-025 REQ->SEND on an edge sampling fmt_grant_i=1; rr SHALL become chosen+1 mod 3 on that edge. fmt_grant_i SHALL be ignored outside REQ.
REQ-026 SEND SHALL pop one word per cycle for exactly PKT_LEN cycles with fmt_valid_o=1.
REQ-027 In SEND: fmt_start_o=1 on the first beat only; fmt_end_o=1 on the last beat only. There SHALL be no stall in SEND.
REQ-028 After the last beat the FSM SHALL return to IDLE. The next fmt_req_o SHALL assert no earlier than 1 cycle after fmt_end_o.
REQ-029 Payload order SHALL equal arrival order per channel; fmt_data_o SHALL be 0 when fmt_valid_o=0.
REQ-030 ch_margin_o and ovf_o SHALL reflect registered state (1-cycle latency after a push or pop).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be FIFO_DEPTH+1 values wide.

Reset
REQ-032 While rstn=1: state=IDLE, rr=0, all counts and pointers 0, all outputs 0 except ch_margin_o=FIFO_DEPTH each.
REQ-033 Reset asserted mid-packet SHALL abort immediately; the packet is discarded and no partial fmt_end_o is issued.
REQ-034 Sticky flags SHALL clear only on reset.

Structure
REQ-035 Package mcdt_fmt_pkg SHALL hold the state enum, NUM_CH=3, and default PKT_LEN/FIFO_DEPTH.
REQ-036 The per-channel buffer SHALL be a sub-module mcdt_fmt_fifo (push/pop/data/count/full/empty), instantiated 3 times.

Verification
REQ-037 4 words C0_0000..C0_0003 on id 0, grant held 1 -> req, then 4 beats in order, start on beat 0, end on beat 3, chid 0, length 4.
REQ-038 Channels 0/1/2 each filled to 4, grant always 1 -> packets served in order ch0, ch1, ch2; rr returns to 0.
REQ-039 20 words on id 1 with grant held 0 -> 16 kept, ovf_o[1]=1, ch_margin_o[1]=0; after grants, words 0..15 are delivered and words 16..19 are lost.
REQ-040 Word on id 3 -> bad_id_o=1, no FIFO count change.
REQ-041 rstn pulsed during beat 2 of a SEND -> all outputs at reset values, margins 16, no fmt_end_o.
REQ-042 Pushes on id 2 every cycle during a ch2 SEND -> count unchanged across the packet, no data loss or reordering.
